// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU control, R-type funct codes,
// the ALU operation enum and the bit positions inside the wb/mem/ex control bundles.
package execute_stage_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_ZERO
  } alu_op_e;

  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_MEMREAD  = 1;
  localparam int MEM_MEMWRITE = 0;
  localparam int EX_REGDST    = 3;
  localparam int EX_ALUOP_HI  = 2;
  localparam int EX_ALUOP_LO  = 1;
  localparam int EX_ALUSRC    = 0;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage bundled as one interface.
interface execute_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [1:0]        wb_in;
  logic [2:0]        mem_in;
  logic [3:0]        ex_in;
  logic [DATA_W-1:0] npc_in;
  logic [DATA_W-1:0] rd1_in;
  logic [DATA_W-1:0] rd2_in;
  logic [DATA_W-1:0] imm_in;
  logic [4:0]        rt_in;
  logic [4:0]        rd_in;

  logic              out_valid;
  logic [1:0]        wb_out;
  logic [2:0]        mem_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] rd2_out;
  logic [DATA_W-1:0] br_target_out;
  logic              zero_out;
  logic [4:0]        dest_out;
  logic [CNT_W-1:0]  illegal_cnt;

  modport slave (
    input  stall, flush, in_valid, wb_in, mem_in, ex_in, npc_in,
           rd1_in, rd2_in, imm_in, rt_in, rd_in,
    output out_valid, wb_out, mem_out, alu_result_out, rd2_out,
           br_target_out, zero_out, dest_out, illegal_cnt
  );

  modport master (
    output stall, flush, in_valid, wb_in, mem_in, ex_in, npc_in,
           rd1_in, rd2_in, imm_in, rt_in, rd_in,
    input  out_valid, wb_out, mem_out, alu_result_out, rd2_out,
           br_target_out, zero_out, dest_out, illegal_cnt
  );
endinterface

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage; add/sub wrap, SLT compares signed.
module exec_alu
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  alu_op_e                  i_op,
  output logic        [DATA_W-1:0] o_result
);

  logic w_lt;
  assign w_lt = (i_a < i_b);

  always_comb begin
    o_result = '0;
    unique case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_SLT:  o_result = {{(DATA_W-1){1'b0}}, w_lt};
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage with EX/MEM pipeline register: ALU, branch target, destination
// select, bubble handling (flush > stall > capture) and a saturating illegal-funct counter.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input logic          clk,
  input logic          rst,
  execute_stage_if.slave bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic [1:0]               w_aluop;
  logic [5:0]               w_funct;
  alu_op_e                  w_op;
  logic                     w_illegal;
  logic                     w_keep;
  logic signed [DATA_W-1:0] w_a;
  logic signed [DATA_W-1:0] w_b;
  logic        [DATA_W-1:0] w_res;
  logic        [DATA_W-1:0] w_br;
  logic        [4:0]        w_dest;

  assign w_aluop = bus.ex_in[EX_ALUOP_HI:EX_ALUOP_LO];
  assign w_funct = bus.imm_in[5:0];
  assign w_a     = bus.rd1_in;
  assign w_b     = bus.ex_in[EX_ALUSRC] ? bus.imm_in : bus.rd2_in;
  assign w_br    = bus.npc_in + (bus.imm_in << 2);
  assign w_dest  = bus.ex_in[EX_REGDST] ? bus.rd_in : bus.rt_in;
  assign w_keep  = bus.in_valid & ~w_illegal;

  always_comb begin
    w_op      = ALU_ADD;
    w_illegal = 1'b0;
    case (w_aluop)
      ALUOP_SUB: w_op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (w_funct)
          FUNCT_ADD: w_op = ALU_ADD;
          FUNCT_SUB: w_op = ALU_SUB;
          FUNCT_AND: w_op = ALU_AND;
          FUNCT_OR:  w_op = ALU_OR;
          FUNCT_SLT: w_op = ALU_SLT;
          default: begin
            w_op      = ALU_ZERO;
            w_illegal = 1'b1;
          end
        endcase
      end
      default: w_op = ALU_ADD;
    endcase
  end

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (w_op),
    .o_result (w_res)
  );

  // EX/MEM register boundary (p1)
  logic              r_vld_p1;
  logic [1:0]        r_wb_p1;
  logic [2:0]        r_mem_p1;
  logic [DATA_W-1:0] r_alu_p1;
  logic [DATA_W-1:0] r_rd2_p1;
  logic [DATA_W-1:0] r_br_p1;
  logic              r_zero_p1;
  logic [4:0]        r_dest_p1;
  logic [CNT_W-1:0]  r_cnt_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_wb_p1   <= '0;
      r_mem_p1  <= '0;
      r_alu_p1  <= '0;
      r_rd2_p1  <= '0;
      r_br_p1   <= '0;
      r_zero_p1 <= 1'b0;
      r_dest_p1 <= '0;
      r_cnt_p1  <= '0;
    end else if (bus.flush) begin
      r_vld_p1 <= 1'b0;
      r_wb_p1  <= '0;
      r_mem_p1 <= '0;
    end else if (!bus.stall) begin
      r_vld_p1  <= w_keep;
      r_wb_p1   <= w_keep ? bus.wb_in  : 2'b00;
      r_mem_p1  <= w_keep ? bus.mem_in : 3'b000;
      r_alu_p1  <= w_res;
      r_rd2_p1  <= bus.rd2_in;
      r_br_p1   <= w_br;
      r_zero_p1 <= (w_res == '0);
      r_dest_p1 <= w_dest;
      if (bus.in_valid && w_illegal)
        r_cnt_p1 <= sat_inc(r_cnt_p1);
    end
  end

  assign bus.out_valid      = r_vld_p1;
  assign bus.wb_out         = r_wb_p1;
  assign bus.mem_out        = r_mem_p1;
  assign bus.alu_result_out = r_alu_p1;
  assign bus.rd2_out        = r_rd2_p1;
  assign bus.br_target_out  = r_br_p1;
  assign bus.zero_out       = r_zero_p1;
  assign bus.dest_out       = r_dest_p1;
  assign bus.illegal_cnt    = r_cnt_p1;

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width in bits.
REQ-002 Parameter CNT_W, default 8, width of the illegal-funct counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  hold EX/MEM register contents.
REQ-006 flush  input  1  load a bubble into EX/MEM register.
REQ-007 in_valid  input  1  ID/EX slot holds a real instruction.
REQ-008 wb_in  input  2  {regwrite, memtoreg} from decode control.
REQ-009 mem_in  input  3  {branch, memread, memwrite} from decode control.
REQ-010 ex_in  input  4  {regdst, aluop[1:0], alusrc} from decode control.
REQ-011 npc_in  input  DATA_W  PC+4 of the instruction.
REQ-012 rd1_in, rd2_in  input  DATA_W each  register-file read data.
REQ-013 imm_in  input  DATA_W  sign-extended immediate; imm_in[5:0] is funct.
REQ-014 rt_in, rd_in  input  5 each  candidate destination register numbers.
REQ-015 out_valid  output  1  EX/MEM slot holds a real instruction.
REQ-016 wb_out, mem_out  output  2 / 3  registered control passed downstream.
REQ-017 alu_result_out, rd2_out, br_target_out  output  DATA_W each  registered ALU result, store data, branch target.
REQ-018 zero_out  output  1  registered (ALU result == 0).
REQ-019 dest_out  output  5  registered destination register.
REQ-020 illegal_cnt  output  CNT_W  count of illegal R-type functs captured.

Function
REQ-021 ALU operand B SHALL be imm_in when alusrc=1, else rd2_in.
REQ-022 aluop 00 SHALL add, 01 SHALL subtract, 10 SHALL decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 signed set-less-than; aluop 11 SHALL add.
REQ-023 Add/sub SHALL wrap modulo 2^DATA_W; no overflow flag.
REQ-024 SLT result SHALL be 1 when signed A < signed B, else 0, zero-extended.
REQ-025 An aluop=10 instruction with any other funct SHALL be illegal: ALU result 0, wb and mem captured as 0, out_valid captured as 0.
REQ-026 br_target SHALL be npc_in + (imm_in << 2), wrapping modulo 2^DATA_W.
REQ-027 dest SHALL be rd_in when regdst=1, else rt_in.
REQ-028 Latency SHALL be one cycle: inputs present before edge N appear on outputs after edge N.
REQ-029 Priority per edge: flush > stall > capture.
REQ-030 flush SHALL set out_valid, wb_out, mem_out to 0; data outputs hold previous values.
REQ-031 stall (flush=0) SHALL hold every output, including illegal_cnt.
REQ-032 Capture with in_valid=0 SHALL load out_valid=0, wb_out=0, mem_out=0; data fields load normally.
REQ-033 illegal_cnt SHALL increment by 1 on each capture of a valid illegal instruction, saturate at all-ones, never wrap; it SHALL not increment on flush or stall edges.
REQ-034 The bubble-load rules (REQ-030, REQ-032) SHALL produce no write-back or memory side effects downstream.

Reset
REQ-035 rst=1 SHALL immediately, without a clock edge, force every output and illegal_cnt to 0.
REQ-036 Deassertion of rst SHALL be followed by normal capture on the next rising edge; reset asserted mid-stall or mid-flush SHALL take precedence.

Structure
REQ-037 A shared package SHALL hold the aluop encodings, funct constants, ALU-operation enum and bit positions of the wb/mem/ex fields.
REQ-038 The ALU SHALL be a combinational sub-module exec_alu (operands, operation in; result out); all state stays in execute_stage.

Verification
REQ-039 R-type add: ex=1100, wb=10, rd1=5, rd2=7, funct=100000, rd=9 -> next cycle alu_result=12, dest=9, wb_out=10, out_valid=1, zero=0.
REQ-040 LW: ex=0001, rd1=0x100, imm=0xFFFFFFFC -> alu_result=0xFC, dest=rt, mem_out=010, wb_out=11.
REQ-041 BEQ: ex=0010, mem=100, rd1=rd2=3, npc=0x40, imm=4 -> zero=1, br_target=0x50.
REQ-042 SLT signed: rd1=0xFFFFFFFF, rd2=1, funct=101010 -> alu_result=1; swapped operands -> 0.
REQ-043 Illegal funct 111111 captured valid 300 times -> out_valid=0, wb_out=mem_out=0 each time, illegal_cnt saturates at 255.
REQ-044 stall and flush together mid-stream, then rst pulse between edges -> bubble loaded, then all outputs 0 asynchronously; stall alone holds outputs for 3 cycles unchanged.
